// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling constants and default frame shape.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned MID_TICK    = 7;
  localparam int unsigned DBITS_DEF   = 8;
  localparam int unsigned SB_TICK_DEF = 16;

  // Tick counter must hold SB_TICK-1 = 31 for two stop bits.
  localparam int unsigned TICK_W  = 5;
  localparam int unsigned NBITS_W = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset value selectable.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive engine: 16x oversampled start/data/stop framing, LSB-first, registered outputs.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DBITS   = DBITS_DEF,
  parameter int unsigned SB_TICK = SB_TICK_DEF
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  input  logic             sample_tick,
  output logic [DBITS-1:0] data_out,
  output logic             rx_done,
  output logic             frame_err,
  output logic [1:0]       state_out
);

  logic               rx_s;
  logic [1:0]         state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [NBITS_W-1:0] nbits_q, nbits_d;
  logic [DBITS-1:0]   shift_q, shift_d;
  logic [DBITS-1:0]   data_q, data_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk_i(clk_100MHz),
    .rst_i(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      nbits_q <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      nbits_q <= nbits_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state and output logic; idle leaves on a low line without waiting for a tick.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    nbits_d = nbits_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (sample_tick) begin
          if (tick_q == TICK_W'(MID_TICK)) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              nbits_d = '0;
            end else begin
              // Line back high at the start-bit midpoint: treat as noise.
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      DATA: begin
        if (sample_tick) begin
          if (tick_q == TICK_W'(OVERSAMPLE - 1)) begin
            shift_d = {rx_s, shift_q[DBITS-1:1]};
            tick_d  = '0;
            if (nbits_q == NBITS_W'(DBITS - 1)) begin
              state_d = STOP;
            end else begin
              nbits_d = nbits_q + NBITS_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      STOP: begin
        if (sample_tick) begin
          if (tick_q == TICK_W'(SB_TICK - 1)) begin
            data_d  = shift_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  assign data_out  = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign state_out = state_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive engine, the receive half of the UART system. Consumes the asynchronous `rx` line and the shared 16x oversampling `sample_tick` from the baud rate generator. Delivers each assembled data word with a one-cycle `rx_done` strobe to the receive FIFO, together with a framing-error flag. Frame format is 8N1 by default: 1 start bit, DBITS data bits LSB-first, and 1 stop bit.

## Interface
- `DBITS`, default 8: data bits per frame; legal range 5..8.
- `SB_TICK`, default 16: sample ticks spent in the stop bit; legal values 16, 24, 32 (1, 1.5, 2 stop bits).
- `clk_100MHz`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `sample_tick`  in  1  one-cycle pulse at 16x the baud rate.
- `data_out`  out  DBITS  last received word; holds until the next frame completes.
- `rx_done`  out  1  one-cycle pulse when a frame completes (FIFO write enable).
- `frame_err`  out  1  set when the stop-bit sample is 0; valid with `rx_done` and held until the next `rx_done`.
- `state_out`  out  2  current state, for debug.

## Operation
- **Input synchronizer.** `rx` passes through a two-flop synchronizer with reset value 1. All logic uses the synchronized value `rx_s`.
- **States.** idle=2'b00, start=2'b01, data=2'b10, stop=2'b11.
  - **idle.** On `rx_s`==0, go to start with tick=0. No `sample_tick` is needed to leave idle.
  - **start.** On each `sample_tick`:
    - If tick==7 (start-bit midpoint) and `rx_s`==0: go to data, tick=0, nbits=0.
    - If tick==7 and `rx_s`==1: this is a glitch; go to idle with no output.
    - Otherwise, tick+1.
  - **data.** On each `sample_tick`:
    - If tick==15: shift right, shift_reg = {`rx_s`, shift_reg[DBITS-1:1]}, and set tick=0. If nbits==DBITS-1, go to stop; otherwise nbits+1.
    - Otherwise, tick+1.
  - **stop.** On each `sample_tick`:
    - If tick==SB_TICK-1: `data_out`←shift_reg, `frame_err`←~`rx_s`, pulse `rx_done`, go to idle.
    - Otherwise, tick+1.
- **Tick counter.** Counter width is 5 bits so that SB_TICK=32 fits. The counter does not wrap in any state.
- **nbits counter.** Width is 3 bits; it counts 0..DBITS-1.
- **Bit alignment.** With DBITS=8 the first received bit lands in `data_out[0]` (LSB-first). For DBITS<8 the word is right-justified.
- **Missing ticks.** If `sample_tick` never arrives, the FSM stays frozen in its current state (except the idle→start transition); there is no timeout.
- **Framing error.** A framing error still delivers the data word with `rx_done`. The block does not drop the frame.
- **Line held low (break).** Produces repeated 0x00 frames with `frame_err`=1, since idle re-enters start immediately.
- **Back-to-back frames.** Leaving stop at the stop-bit midpoint leaves half a bit of margin. A start edge seen in the cycle after `rx_done` is accepted.

## Timing
- **Reset values.** All take effect at the first `clk_100MHz` edge with `reset`=1:
  - state=idle, tick=0, nbits=0, shift_reg=0.
  - `data_out`=0, `rx_done`=0, `frame_err`=0, `state_out`=2'b00.
  - Both synchronizer flops = 1.
- **Input latency.** `rx` to `rx_s` is 2 clocks. The start edge is detected 2–3 clocks after the pin falls.
- **Output latency.** `rx_done`, `data_out` and `frame_err` are registered. They update on the edge that processes the final stop `sample_tick`, so they are visible the cycle after that tick is sampled. `rx_done` is high for exactly one cycle.
- **Sample points.** Data bits are sampled 16 ticks apart, each at its bit midpoint (tick 7 of start plus 16·k). The stop bit is sampled SB_TICK ticks after the last data bit.
- **Reset mid-frame.** Aborts the frame: no `rx_done`, and `data_out` and `frame_err` are cleared. After reset, a low line is treated as a new start bit.
- **Simultaneous events.** `reset` dominates `sample_tick` and `rx`. `sample_tick` in the same cycle as the idle→start transition is ignored; counting starts at the next tick.
- **Pulse width.** `sample_tick` is a single-cycle pulse; at most one tick is processed per cycle.

## Structure
- **Shared package `uart_pkg`.** Holds:
  - state encodings (IDLE, START, DATA, STOP), shared with the transmitter;
  - `OVERSAMPLE`=16 and `MID_TICK`=7;
  - default `DBITS` and `SB_TICK`.
- **Sub-module `sync_2ff`.** A two-flop synchronizer with a parameterized reset value, reusable for other asynchronous inputs (buttons, CTS).
- **Top-level FSM.** Lives in `uart_receiver`, in two-block style: a registered state block plus a combinational next-state block.

## Test plan
- **Single frame.** Send 0x55 at 16x ticks (1 tick per 4 clocks) → one `rx_done` pulse, `data_out`=0x55, `frame_err`=0, `state_out` back to 00.
- **Start-bit glitch.** Drive `rx` low for 4 ticks, then high → no `rx_done`, FSM returns to idle at tick 7, `data_out` unchanged.
- **Bad stop bit.** Send 0xA3 with the stop bit forced to 0 → `rx_done` pulses, `data_out`=0xA3, `frame_err`=1. A following good 0x0F frame clears `frame_err` to 0.
- **Back-to-back frames.** Send 0xA5 then 0x3C with no idle gap → exactly two `rx_done` pulses, carrying 0xA5 then 0x3C in order.
- **Reset mid-frame.** Assert `reset` for 1 cycle during data bit 4 of 0xFF → no `rx_done`, and all outputs return to their reset values. A subsequent clean 0x81 frame is received correctly.
- **DBITS=7, SB_TICK=32.** Send 0x5A (7-bit) with 2 stop bits → `data_out`=0x5A, and `rx_done` occurs 32 ticks after the last data-bit sample.
